// File: rtl/array_run_ctrl.sv
// Run controller for a two-port PE array: load/store FIFOs, run-cycle counter, store-capture pipeline.
// Optional macro STALL_ON_EMPTY_EN: stall RUN on an empty load FIFO instead of feeding zeros.
`timescale 1ns/1ps

module array_run_fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 8
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [DW-1:0] i_wdata,
    output logic [DW-1:0] o_head,
    output logic          o_full,
    output logic          o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_pop;
    logic          w_push;

    // A push into a full FIFO is still accepted when a pop frees a slot in the same cycle.
    assign w_pop   = i_pop & (r_count != {(AW+1){1'b0}});
    assign w_push  = i_push & ((r_count != (AW+1)'(DEPTH)) | w_pop);
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == {(AW+1){1'b0}});
    assign o_head  = r_mem[r_rd_ptr];

    // Storage array.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers and occupancy count.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {(AW+1){1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

module array_run_ctrl #(
    parameter int DWIDTH     = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_WIDTH  = 16,
    parameter int STORE_LAT  = 2
) (
    input  logic                 Clk,
    input  logic                 Resetn,
    input  logic                 Start,
    input  logic [CNT_WIDTH-1:0] Run_Cycles,
    output logic                 Done,
    input  logic                 Ld_Wr_En,
    input  logic                 Ld_Wr_Sel,
    input  logic [DWIDTH-1:0]    Ld_Wr_Data,
    output logic [1:0]           Ld_Full,
    input  logic                 St_Rd_En,
    input  logic                 St_Rd_Sel,
    output logic [DWIDTH-1:0]    St_Rd_Data,
    output logic [1:0]           St_Empty,
    output logic [DWIDTH-1:0]    Data0_Load,
    output logic [DWIDTH-1:0]    Data1_Load,
    input  logic [DWIDTH-1:0]    Data0_Store,
    input  logic [DWIDTH-1:0]    Data1_Store,
    output logic                 PE_Array_Busy,
    output logic                 Overflow,
    output logic                 Underflow
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                r_state;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [STORE_LAT-1:0]  r_vld;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_ovf;
    logic                  r_unf;
    logic [DWIDTH-1:0]     r_d0;
    logic [DWIDTH-1:0]     r_d1;
    logic [DWIDTH-1:0]     r_st_rd;

    logic                  w_active;
    logic [1:0]            w_ld_push;
    logic [1:0]            w_ld_pop;
    logic [1:0]            w_ld_full;
    logic [1:0]            w_ld_empty;
    logic [1:0]            w_st_push;
    logic [1:0]            w_st_pop;
    logic [1:0]            w_st_full;
    logic [1:0]            w_st_empty;
    logic [1:0]            w_ovf_evt;
    logic [DWIDTH-1:0]     w_ld_head [2];
    logic [DWIDTH-1:0]     w_st_head [2];
    logic [DWIDTH-1:0]     w_st_wdata [2];

`ifdef STALL_ON_EMPTY_EN
    assign w_active = (r_state == S_RUN) & ~w_ld_empty[0] & ~w_ld_empty[1];
`else
    assign w_active = (r_state == S_RUN);
`endif

    assign w_st_wdata[0] = Data0_Store;
    assign w_st_wdata[1] = Data1_Store;

    for (genvar g = 0; g < 2; g++) begin : g_fifo
        assign w_ld_push[g] = Ld_Wr_En & (Ld_Wr_Sel == 1'(g));
        assign w_ld_pop[g]  = w_active & ~w_ld_empty[g];
        assign w_st_push[g] = r_vld[STORE_LAT-1];
        assign w_st_pop[g]  = St_Rd_En & (St_Rd_Sel == 1'(g));
        // A full store FIFO only drops the word when the host is not popping it that cycle.
        assign w_ovf_evt[g] = w_st_push[g] & w_st_full[g] & ~w_st_pop[g];

        array_run_fifo #(.DW(DWIDTH), .DEPTH(FIFO_DEPTH)) u_ld_fifo (
            .i_clk   (Clk),
            .i_rst_n (Resetn),
            .i_push  (w_ld_push[g]),
            .i_pop   (w_ld_pop[g]),
            .i_wdata (Ld_Wr_Data),
            .o_head  (w_ld_head[g]),
            .o_full  (w_ld_full[g]),
            .o_empty (w_ld_empty[g])
        );

        array_run_fifo #(.DW(DWIDTH), .DEPTH(FIFO_DEPTH)) u_st_fifo (
            .i_clk   (Clk),
            .i_rst_n (Resetn),
            .i_push  (w_st_push[g]),
            .i_pop   (w_st_pop[g]),
            .i_wdata (w_st_wdata[g]),
            .o_head  (w_st_head[g]),
            .o_full  (w_st_full[g]),
            .o_empty (w_st_empty[g])
        );
    end

    // Store-capture valid pipeline fed by the busy flag.
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            r_vld <= {STORE_LAT{1'b0}};
        end else begin
            r_vld[0] <= r_busy;
            for (int i = 1; i < STORE_LAT; i++) begin
                r_vld[i] <= r_vld[i-1];
            end
        end
    end

    // Run FSM with registered array-side outputs and sticky error flags.
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            r_state <= S_IDLE;
            r_cnt   <= {CNT_WIDTH{1'b0}};
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
            r_d0    <= {DWIDTH{1'b0}};
            r_d1    <= {DWIDTH{1'b0}};
        end else begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (Start) begin
                        if (Run_Cycles != {CNT_WIDTH{1'b0}}) begin
                            r_cnt   <= Run_Cycles;
                            r_ovf   <= 1'b0;
                            r_unf   <= 1'b0;
                            r_state <= S_RUN;
                        end else begin
                            r_state <= S_DONE;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    if (w_active) begin
                        r_busy <= 1'b1;
                        r_cnt  <= r_cnt - CNT_WIDTH'(1);
                        r_d0   <= w_ld_empty[0] ? {DWIDTH{1'b0}} : w_ld_head[0];
                        r_d1   <= w_ld_empty[1] ? {DWIDTH{1'b0}} : w_ld_head[1];
                        if (w_ld_empty[0] | w_ld_empty[1]) begin
                            r_unf <= 1'b1;
                        end
                        if (r_cnt == CNT_WIDTH'(1)) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    // The last busy cycle has not entered the pipeline yet on the first DRAIN cycle.
                    if (!r_busy && (r_vld == {STORE_LAT{1'b0}})) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
            if (|w_ovf_evt) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // Registered host read port; an empty read holds the previous word.
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            r_st_rd <= {DWIDTH{1'b0}};
        end else if (St_Rd_En && !w_st_empty[St_Rd_Sel]) begin
            r_st_rd <= St_Rd_Sel ? w_st_head[1] : w_st_head[0];
        end
    end

    assign Done          = r_done;
    assign PE_Array_Busy = r_busy;
    assign Overflow      = r_ovf;
    assign Underflow     = r_unf;
    assign Data0_Load    = r_d0;
    assign Data1_Load    = r_d1;
    assign St_Rd_Data    = r_st_rd;
    assign Ld_Full       = w_ld_full;
    assign St_Empty      = w_st_empty;
endmodule

// File: tb/tb_array_run_ctrl.sv
// Scoreboard bench for array_run_ctrl: directed runs with a 2-stage PE array model on the store ports.
`timescale 1ns/1ps

module tb_array_run_ctrl;
    localparam int DW = 32;
    localparam int CW = 16;

    logic          Clk = 1'b0;
    logic          Resetn = 1'b0;
    logic          Start = 1'b0;
    logic [CW-1:0] Run_Cycles = '0;
    logic          Done;
    logic          Ld_Wr_En = 1'b0;
    logic          Ld_Wr_Sel = 1'b0;
    logic [DW-1:0] Ld_Wr_Data = '0;
    logic [1:0]    Ld_Full;
    logic          St_Rd_En = 1'b0;
    logic          St_Rd_Sel = 1'b0;
    logic [DW-1:0] St_Rd_Data;
    logic [1:0]    St_Empty;
    logic [DW-1:0] Data0_Load, Data1_Load;
    logic [DW-1:0] Data0_Store = '0, Data1_Store = '0;
    logic [DW-1:0] s0 = '0, s1 = '0;
    logic          PE_Array_Busy, Overflow, Underflow;

    int n_chk = 0;
    int n_fail = 0;
    int busy_cnt = 0, busy_rises = 0, done_cnt = 0;
    int b_busy, b_rise, b_done;
    logic prev_busy = 1'b0;
    logic r_chk_rd = 1'b0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] mon_e;

    array_run_ctrl #(.DWIDTH(DW), .FIFO_DEPTH(8), .CNT_WIDTH(CW), .STORE_LAT(2)) dut (
        .Clk(Clk), .Resetn(Resetn), .Start(Start), .Run_Cycles(Run_Cycles), .Done(Done),
        .Ld_Wr_En(Ld_Wr_En), .Ld_Wr_Sel(Ld_Wr_Sel), .Ld_Wr_Data(Ld_Wr_Data), .Ld_Full(Ld_Full),
        .St_Rd_En(St_Rd_En), .St_Rd_Sel(St_Rd_Sel), .St_Rd_Data(St_Rd_Data), .St_Empty(St_Empty),
        .Data0_Load(Data0_Load), .Data1_Load(Data1_Load),
        .Data0_Store(Data0_Store), .Data1_Store(Data1_Store),
        .PE_Array_Busy(PE_Array_Busy), .Overflow(Overflow), .Underflow(Underflow)
    );

    always #5 Clk = ~Clk;

    // PE array model: two-cycle latency, store = load + 1 (port 0) / + 2 (port 1).
    always @(posedge Clk) begin
        s0 <= Data0_Load;
        s1 <= Data1_Load;
        Data0_Store <= s0 + 32'd1;
        Data1_Store <= s1 + 32'd2;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compare read data the cycle after a host read, and count busy/done activity.
    always @(posedge Clk) r_chk_rd <= St_Rd_En & Resetn;
    always @(negedge Clk) begin
        if (r_chk_rd) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL st_rd_data: got %0h with no expected value queued", St_Rd_Data);
            end else begin
                mon_e = exp_q.pop_front();
                check("st_rd_data", St_Rd_Data, mon_e);
            end
        end
        if (PE_Array_Busy) busy_cnt++;
        if (PE_Array_Busy && !prev_busy) busy_rises++;
        prev_busy = PE_Array_Busy;
        if (Done) done_cnt++;
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic push_ld(input logic sel, input logic [DW-1:0] d);
        Ld_Wr_En = 1'b1; Ld_Wr_Sel = sel; Ld_Wr_Data = d;
        tick();
        Ld_Wr_En = 1'b0;
    endtask

    task automatic pop_st(input logic sel, input logic [DW-1:0] e);
        St_Rd_En = 1'b1; St_Rd_Sel = sel;
        exp_q.push_back(e);
        tick();
        St_Rd_En = 1'b0;
    endtask

    task automatic start_run(input logic [CW-1:0] n);
        Run_Cycles = n; Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int base);
        for (int i = 0; i < 200 && done_cnt == base; i++) @(negedge Clk);
        repeat (3) tick();
        check(name, done_cnt - base, 1);
    endtask

    task automatic do_reset();
        Resetn = 1'b0;
        tick(); tick();
        Resetn = 1'b1;
        tick();
    endtask

    task automatic mark();
        b_busy = busy_cnt; b_rise = busy_rises; b_done = done_cnt;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #12;
        check("rst_done", Done, 0);
        check("rst_busy", PE_Array_Busy, 0);
        check("rst_ld_full", Ld_Full, 2'b00);
        check("rst_st_empty", St_Empty, 2'b11);
        check("rst_flags", {Overflow, Underflow}, 2'b00);
        check("rst_rd_data", St_Rd_Data, 0);
        check("rst_load", {Data0_Load, Data1_Load}, 0);
        tick();
        Resetn = 1'b1;
        tick();

        // Basic 3-cycle run
        for (int i = 0; i < 3; i++) begin
            push_ld(1'b0, 32'd10 + 32'(i));
            push_ld(1'b1, 32'd20 + 32'(i));
        end
        mark();
        start_run(16'd3);
        wait_done("t1_done_pulse", b_done);
        check("t1_busy_cycles", busy_cnt - b_busy, 3);
        check("t1_busy_contig", busy_rises - b_rise, 1);
        check("t1_flags", {Overflow, Underflow}, 2'b00);
        check("t1_st_empty", St_Empty, 2'b00);
        for (int i = 0; i < 3; i++) pop_st(1'b0, 32'd11 + 32'(i));
        for (int i = 0; i < 3; i++) pop_st(1'b1, 32'd22 + 32'(i));
        pop_st(1'b0, 32'd24);
        tick();
        check("t1_st_drained", St_Empty, 2'b11);

        // Zero-length run
        mark();
        start_run(16'd0);
        @(negedge Clk);
        check("t2_done_early", Done, 0);
        @(negedge Clk);
        check("t2_done", Done, 1);
        @(negedge Clk);
        check("t2_done_one_cycle", Done, 0);
        tick();
        check("t2_no_busy", busy_cnt - b_busy, 0);
        check("t2_fifos", {Ld_Full, St_Empty}, 4'b0011);

        // Late third/fourth words
        push_ld(1'b0, 32'd30); push_ld(1'b1, 32'd40);
        push_ld(1'b0, 32'd31); push_ld(1'b1, 32'd41);
        mark();
        start_run(16'd4);
        repeat (5) tick();
        push_ld(1'b0, 32'd32); push_ld(1'b1, 32'd42);
        push_ld(1'b0, 32'd33); push_ld(1'b1, 32'd43);
        wait_done("t3_done_pulse", b_done);
        check("t3_busy_cycles", busy_cnt - b_busy, 4);
`ifdef STALL_ON_EMPTY_EN
        check("t3_busy_gap", (busy_rises - b_rise) >= 2, 1);
        check("t3_underflow", Underflow, 0);
        for (int i = 0; i < 4; i++) pop_st(1'b0, 32'd31 + 32'(i));
        for (int i = 0; i < 4; i++) pop_st(1'b1, 32'd42 + 32'(i));
`else
        check("t3_busy_contig", busy_rises - b_rise, 1);
        check("t3_underflow", Underflow, 1);
        pop_st(1'b0, 32'd31); pop_st(1'b0, 32'd32); pop_st(1'b0, 32'd1); pop_st(1'b0, 32'd1);
        pop_st(1'b1, 32'd42); pop_st(1'b1, 32'd43); pop_st(1'b1, 32'd2); pop_st(1'b1, 32'd2);
`endif
        tick();
        do_reset();

        // Store FIFO overflow
        for (int i = 0; i < 7; i++) begin
            push_ld(1'b0, 32'd50 + 32'(i));
            push_ld(1'b1, 32'd60 + 32'(i));
        end
        mark();
        start_run(16'd7);
        wait_done("t4_prefill_done", b_done);
        check("t4_no_ovf_prefill", Overflow, 0);
        for (int i = 0; i < 3; i++) begin
            push_ld(1'b0, 32'd70 + 32'(i));
            push_ld(1'b1, 32'd80 + 32'(i));
        end
        mark();
        start_run(16'd3);
        wait_done("t4_done", b_done);
        check("t4_overflow", Overflow, 1);
        check("t4_underflow", Underflow, 0);
        for (int i = 0; i < 7; i++) pop_st(1'b0, 32'd51 + 32'(i));
        pop_st(1'b0, 32'd71);
        for (int i = 0; i < 7; i++) pop_st(1'b1, 32'd62 + 32'(i));
        pop_st(1'b1, 32'd82);
        tick();
        check("t4_st_drained", St_Empty, 2'b11);

        // Reset in the middle of a run
        for (int i = 0; i < 4; i++) begin
            push_ld(1'b0, 32'd90 + 32'(i));
            push_ld(1'b1, 32'd100 + 32'(i));
        end
        mark();
        start_run(16'd4);
        check("t5_ovf_cleared", Overflow, 0);
        tick();
        check("t5_busy_mid_run", PE_Array_Busy, 1);
        Resetn = 1'b0;
        #1;
        check("t5_rst_busy_done", {PE_Array_Busy, Done}, 2'b00);
        check("t5_rst_flags", {Overflow, Underflow}, 2'b00);
        check("t5_rst_load", {Data0_Load, Data1_Load}, 0);
        check("t5_rst_rd_data", St_Rd_Data, 0);
        check("t5_rst_st_empty", St_Empty, 2'b11);
        check("t5_rst_ld_full", Ld_Full, 2'b00);
        tick(); tick();
        Resetn = 1'b1;
        repeat (20) tick();
        check("t5_no_done", done_cnt - b_done, 0);
        check("t5_st_empty_after", St_Empty, 2'b11);

        // Push and pop on a full load FIFO in the same cycle
        for (int i = 0; i < 8; i++) begin
            push_ld(1'b0, 32'hB0 + 32'(i));
            push_ld(1'b1, 32'hC0 + 32'(i));
        end
        check("t6_ld_full", Ld_Full, 2'b11);
        mark();
        start_run(16'd2);
        push_ld(1'b0, 32'hBF);
        check("t6_ld_full_kept", Ld_Full, 2'b01);
        wait_done("t6_done1", b_done);
        pop_st(1'b0, 32'hB1); pop_st(1'b0, 32'hB2);
        pop_st(1'b1, 32'hC2); pop_st(1'b1, 32'hC3);
        push_ld(1'b1, 32'hCF);
        mark();
        start_run(16'd7);
        wait_done("t6_done2", b_done);
        check("t6_no_ovf", Overflow, 0);
        for (int i = 0; i < 6; i++) pop_st(1'b0, 32'hB3 + 32'(i));
        pop_st(1'b0, 32'hC0);
        for (int i = 0; i < 6; i++) pop_st(1'b1, 32'hC4 + 32'(i));
        pop_st(1'b1, 32'hD1);
        tick(); tick();
        check("t6_ld_empty", Ld_Full, 2'b00);
        check("sb_queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
